// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular-automaton engine.
package eca_pkg;

  typedef enum logic [1:0] {
    BND_ZERO = 2'd0,
    BND_ONE  = 2'd1,
    BND_WRAP = 2'd2,
    BND_RSVD = 2'd3
  } bnd_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] RULE_30  = 8'd30;
  localparam logic [7:0] RULE_90  = 8'd90;
  localparam logic [7:0] RULE_110 = 8'd110;

endpackage

// File: rtl/eca_cell.sv
// One automaton cell: the {L, C, R} neighbourhood selects a bit of the rule number.
module eca_cell (
  input  logic [2:0] nbr,
  input  logic [7:0] rule,
  output logic       nxt
);

  assign nxt = rule[nbr];

endmodule

// File: rtl/eca_engine.sv
// Elementary cellular-automaton engine: runtime rule and boundary mode,
// runs a requested number of generations with start/busy/done handshake.
module eca_engine
  import eca_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int CNT_W = 16,
  parameter int GEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [7:0]       rule,
  input  logic [1:0]       bnd_mode,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [GEN_W-1:0] gen
);

  state_e           state, state_nxt;
  logic [7:0]       rule_r;
  bnd_mode_e        mode_r;
  logic [CNT_W-1:0] rem;
  logic             edge_lo, edge_hi;
  logic [WIDTH+1:0] ext;
  logic [WIDTH-1:0] q_nxt;

  // edge_lo stands in for q[-1], edge_hi for q[WIDTH]; reserved mode behaves as zero.
  always_comb begin
    unique case (mode_r)
      BND_ONE:  begin edge_lo = 1'b1;         edge_hi = 1'b1; end
      BND_WRAP: begin edge_lo = q[WIDTH-1];   edge_hi = q[0]; end
      default:  begin edge_lo = 1'b0;         edge_hi = 1'b0; end
    endcase
  end

  assign ext = {edge_hi, q, edge_lo};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    eca_cell u_cell (
      .nbr  (ext[i+2:i]),
      .rule (rule_r),
      .nxt  (q_nxt[i])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (!load && start && steps != '0) state_nxt = S_RUN;
      S_RUN:  if (load || rem == CNT_W'(1))      state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
  end

  // Load always wins; start is only honoured from IDLE, so it is never queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      gen    <= '0;
      rule_r <= '0;
      mode_r <= BND_ZERO;
      rem    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        q   <= data;
        gen <= '0;
      end else if (state == S_IDLE) begin
        if (start) begin
          rule_r <= rule;
          mode_r <= bnd_mode_e'(bnd_mode);
          rem    <= steps;
          if (steps == '0) done <= 1'b1;
        end
      end else begin
        q   <= q_nxt;
        gen <= gen + GEN_W'(1);
        rem <= rem - CNT_W'(1);
        if (rem == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eca_engine.sv
// Directed self-checking bench for eca_engine at WIDTH = 8.
module tb_eca_engine;
  import eca_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam int GEN_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] data;
  logic [7:0]       rule;
  logic [1:0]       bnd_mode;
  logic             start;
  logic [CNT_W-1:0] steps;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [GEN_W-1:0] gen;

  int checks = 0;
  int errors = 0;

  eca_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GEN_W(GEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data     (data),
    .rule     (rule),
    .bnd_mode (bnd_mode),
    .start    (start),
    .steps    (steps),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .gen      (gen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs set before calling step() are sampled at the coming edge; outputs read 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1;
    data = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; data = '0; rule = '0;
    bnd_mode = 2'd0; start = 1'b0; steps = '0;
    #12;
    check("rst_q", 32'(q), 32'h0);
    check("rst_gen", gen, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: rule 110, zero boundary, 3 steps
    do_load(8'h01);
    check("t1_load_q", 32'(q), 32'h01);
    check("t1_load_gen", gen, 32'd0);
    rule = RULE_110; bnd_mode = 2'd0; steps = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_e0_busy", 32'(busy), 32'd1);
    check("t1_e0_q", 32'(q), 32'h01);
    step();
    check("t1_e1_q", 32'(q), 32'h03);
    check("t1_e1_done", 32'(done), 32'd0);
    step();
    check("t1_e2_q", 32'(q), 32'h07);
    check("t1_e2_busy", 32'(busy), 32'd1);
    step();
    check("t1_e3_q", 32'(q), 32'h0D);
    check("t1_e3_gen", gen, 32'd3);
    check("t1_e3_busy", 32'(busy), 32'd0);
    check("t1_e3_done", 32'(done), 32'd1);
    step();
    check("t1_done_clr", 32'(done), 32'd0);
    check("t1_q_hold", 32'(q), 32'h0D);

    // 2: rule 90, wrap boundary, 1 step
    do_load(8'h01);
    rule = RULE_90; bnd_mode = 2'd2; steps = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("t2_busy", 32'(busy), 32'd1);
    step();
    check("t2_q", 32'(q), 32'h82);
    check("t2_gen", gen, 32'd1);
    check("t2_done", 32'(done), 32'd1);

    // 3: rule 204 is identity; then a zero-step start
    do_load(8'h5A);
    rule = 8'd204; bnd_mode = 2'd1; steps = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t3_q", 32'(q), 32'h5A);
    check("t3_gen", gen, 32'd4);
    check("t3_done", 32'(done), 32'd1);
    step();
    steps = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("t3z_done", 32'(done), 32'd1);
    check("t3z_busy", 32'(busy), 32'd0);
    check("t3z_gen", gen, 32'd4);
    check("t3z_q", 32'(q), 32'h5A);
    step();
    check("t3z_done_clr", 32'(done), 32'd0);
    check("t3z_busy2", 32'(busy), 32'd0);

    // 4: load aborts a long run; start during busy is dropped
    do_load(8'h01);
    rule = RULE_110; bnd_mode = 2'd0; steps = 16'd10; start = 1'b1;
    step();
    steps = 16'd1;
    step();
    check("t4_e1_q", 32'(q), 32'h03);
    start = 1'b0;
    step();
    check("t4_e2_q", 32'(q), 32'h07);
    check("t4_e2_gen", gen, 32'd2);
    do_load(8'hF0);
    check("t4_q", 32'(q), 32'hF0);
    check("t4_gen", gen, 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    step();
    check("t4_noqueue_busy", 32'(busy), 32'd0);
    check("t4_noqueue_done", 32'(done), 32'd0);
    check("t4_noqueue_q", 32'(q), 32'hF0);

    // 5: asynchronous reset between edges, then rule 0
    steps = 16'd10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_q", 32'(q), 32'h0);
    check("t5_rst_gen", gen, 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    do_load(8'hFF);
    rule = 8'd0; bnd_mode = 2'd0; steps = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t5_rule0_q", 32'(q), 32'h00);
    check("t5_rule0_done", 32'(done), 32'd1);

    // 6: back-to-back runs; rule changes mid-run are ignored
    step();
    do_load(8'h01);
    rule = RULE_110; steps = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    rule = 8'd0;
    step();
    check("t6_r1_q1", 32'(q), 32'h03);
    step();
    check("t6_r1_q2", 32'(q), 32'h07);
    check("t6_r1_done", 32'(done), 32'd1);
    rule = RULE_30; steps = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    rule = 8'd0;
    check("t6_r2_busy", 32'(busy), 32'd1);
    check("t6_r2_done_clr", 32'(done), 32'd0);
    check("t6_r2_gen0", gen, 32'd2);
    step();
    check("t6_r2_q1", 32'(q), 32'h0C);
    check("t6_r2_gen1", gen, 32'd3);
    step();
    check("t6_r2_q2", 32'(q), 32'h1A);
    check("t6_r2_gen2", gen, 32'd4);
    check("t6_r2_done", 32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
